// File: rtl/prime_seek.sv
// prime_seek: nearest prime above/below the current value by odd trial division through divmod.
// Latency: 1 STEP + 1 CHECK cycle per candidate, plus 2 + divmod latency (W) cycles per divisor tested.
// Backpressure: go/load are only sampled while o_ready=1. They are ignored during a search.
// Ports: clk, rst (sync, active-high); i_go/i_load/i_from/i_dir host requests;
//        o_ready idle/result valid, o_error last search failed, o_res value/result, o_ops divmod calls.

// divmod: sequential restoring remainder unit computing mod = a % b.
// Latency: W cycles from the edge that accepts go until ready rises again.
// Backpressure: go is only sampled while ready=1. A zero divisor sets error and stays idle.
module divmod #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         error,
  output logic [W-1:0] mod
);
  localparam int CW = $clog2(W + 1);

  logic          r_busy;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_rem;

  logic [W:0]    w_trial;
  logic [W-1:0]  w_diff;
  logic          w_ge;

  // Shift one dividend bit into the partial remainder. When the trial value is >= b,
  // the true difference is < b, so the low W bits of the subtraction are exact.
  assign w_trial = {r_rem, r_a[W-1]};
  assign w_ge    = w_trial >= {1'b0, r_b};
  assign w_diff  = w_trial[W-1:0] - r_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
    end else if (!r_busy) begin
      if (go) begin
        if (b == '0) begin
          r_err <= 1'b1;
        end else begin
          r_err  <= 1'b0;
          r_busy <= 1'b1;
          r_cnt  <= CW'(W);
          r_a    <= a;
          r_b    <= b;
          r_rem  <= '0;
        end
      end
    end else begin
      r_rem <= w_ge ? w_diff : w_trial[W-1:0];
      r_a   <= {r_a[W-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign ready = !r_busy;
  assign error = r_err;
  assign mod   = r_rem;
endmodule

module prime_seek #(
  parameter int WIDTH_LOG = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_go,
  input  logic                        i_load,
  input  logic [(1 << WIDTH_LOG)-1:0] i_from,
  input  logic                        i_dir,
  output logic                        o_ready,
  output logic                        o_error,
  output logic [(1 << WIDTH_LOG)-1:0] o_res,
  output logic [15:0]                 o_ops
);
  localparam int W = 1 << WIDTH_LOG;

  typedef enum logic [2:0] {
    S_READY, S_ERROR, S_STEP, S_CHECK, S_WAIT_MOD_DLY, S_WAIT_MOD
  } state_t;

  state_t       r_state, w_state_nxt;
  logic         r_ready, r_error, r_mod_go, r_dir, r_first;
  logic [W-1:0] r_res, r_c, r_div;
  logic [W:0]   r_div_sq;
  logic [15:0]  r_ops;

  logic         w_dm_ready, w_dm_error;
  logic [W-1:0] w_mod;
  logic [W:0]   w_c_ext, w_up1, w_up2, w_dn1, w_dn2, w_cand;
  logic         w_up_take1, w_dn_take1, w_range_err, w_skip, w_is_prime;
  logic         w_load_acc, w_go_acc;

  // Candidate arithmetic is one bit wider than the datapath so that stepping past
  // 2^W-1 (upward) or below zero (downward) shows up in the top bit.
  assign w_c_ext    = {1'b0, r_c};
  assign w_up1      = w_c_ext + (W+1)'(1);
  assign w_up2      = w_c_ext + (W+1)'(2);
  assign w_dn1      = w_c_ext - (W+1)'(1);
  assign w_dn2      = w_c_ext - (W+1)'(2);
  // Only the first step may land on c+-1; an even first candidate other than 2 is skipped.
  assign w_up_take1 = r_first && (w_up1[0] || w_up1 == (W+1)'(2));
  assign w_dn_take1 = r_first && (w_dn1[0] || w_dn1 == (W+1)'(2));
  assign w_cand     = r_dir ? (w_dn_take1 ? w_dn1 : w_dn2) : (w_up_take1 ? w_up1 : w_up2);
  assign w_range_err = w_cand[W] || (r_dir && w_cand < (W+1)'(2));
  // Only an upward search from 0 meets candidate 1. It keeps the first-step rule so that
  // the following candidate is 2 rather than 3.
  assign w_skip     = w_cand < (W+1)'(2);
  assign w_is_prime = r_div_sq > w_c_ext;

  divmod #(.W(W)) u_divmod (
    .clk   (clk),
    .rst   (rst),
    .go    (r_mod_go),
    .a     (r_c),
    .b     (r_div),
    .ready (w_dm_ready),
    .error (w_dm_error),
    .mod   (w_mod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_acc  = 1'b0;
    w_go_acc    = 1'b0;
    case (r_state)
      S_READY, S_ERROR: begin
        if (i_load) begin
          w_load_acc  = 1'b1;
          w_state_nxt = S_READY;
        end else if (i_go) begin
          w_go_acc    = 1'b1;
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (w_range_err) begin
          w_state_nxt = S_ERROR;
        end else if (!w_skip) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK:        w_state_nxt = w_is_prime ? S_READY : S_WAIT_MOD_DLY;
      S_WAIT_MOD_DLY: w_state_nxt = S_WAIT_MOD;
      S_WAIT_MOD: begin
        if (w_dm_error) begin
          w_state_nxt = S_ERROR;
        end else if (w_dm_ready) begin
          w_state_nxt = (w_mod == '0) ? S_STEP : S_CHECK;
        end
      end
      default:        w_state_nxt = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b1;
      r_error  <= 1'b0;
      r_res    <= W'(1);
      r_ops    <= '0;
      r_mod_go <= 1'b0;
      r_dir    <= 1'b0;
      r_first  <= 1'b0;
      r_c      <= '0;
      r_div    <= '0;
      r_div_sq <= '0;
    end else begin
      r_ready  <= (w_state_nxt == S_READY) || (w_state_nxt == S_ERROR);
      r_error  <= w_state_nxt == S_ERROR;
      r_mod_go <= 1'b0;
      case (r_state)
        S_READY, S_ERROR: begin
          if (w_load_acc) begin
            r_res <= i_from;
          end else if (w_go_acc) begin
            r_dir   <= i_dir;
            r_ops   <= '0;
            r_c     <= r_res;
            r_first <= 1'b1;
          end
        end
        S_STEP: begin
          if (!w_range_err) begin
            r_c <= w_cand[W-1:0];
            if (!w_skip) begin
              r_first  <= 1'b0;
              r_div    <= W'(3);
              r_div_sq <= (W+1)'(9);
            end
          end
        end
        S_CHECK: begin
          if (w_is_prime) begin
            r_res <= r_c;
          end else begin
            r_mod_go <= 1'b1;
            if (r_ops != 16'hFFFF) begin
              r_ops <= r_ops + 16'd1;
            end
          end
        end
        S_WAIT_MOD: begin
          // (d+2)^2 = d^2 + 4d + 4: the square tracks the divisor without a multiplier.
          if (!w_dm_error && w_dm_ready && w_mod != '0) begin
            r_div_sq <= r_div_sq + ((W+1)'(r_div) << 2) + (W+1)'(4);
            r_div    <= r_div + W'(2);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_error = r_error;
  assign o_res   = r_res;
  assign o_ops   = r_ops;
endmodule

// File: tb/tb_prime_seek.sv
module tb_prime_seek;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_go = 1'b0;
  logic        i_load = 1'b0;
  logic        i_dir = 1'b0;
  logic [15:0] i_from = '0;
  logic        o_ready, o_error;
  logic [15:0] o_res, o_ops;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what res/error/ops must show whenever the block is idle.
  int exp_res = 1;
  int exp_err = 0;
  int exp_ops = 0;

  prime_seek #(.WIDTH_LOG(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_go    (i_go),
    .i_load  (i_load),
    .i_from  (i_from),
    .i_dir   (i_dir),
    .o_ready (o_ready),
    .o_error (o_error),
    .o_res   (o_res),
    .o_ops   (o_ops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Primality by odd trial division, counting each divisor tried.
  function automatic bit is_prime_cnt(input int n, inout int ops);
    bit p;
    if (n < 2) return 1'b0;
    if (n == 2) return 1'b1;
    if (n % 2 == 0) return 1'b0;
    p = 1'b1;
    for (int d = 3; p && d * d <= n; d += 2) begin
      ops++;
      if (n % d == 0) p = 1'b0;
    end
    return p;
  endfunction

  // Nearest prime strictly above/below seed within 16 bits, plus total divisor tests.
  function automatic void model_search(input int seed, input bit down,
                                       output int res, output int err, output int ops);
    ops = 0;
    err = 1;
    res = seed;
    if (!down) begin
      for (int n = seed + 1; err == 1 && n <= 65535; n++)
        if (is_prime_cnt(n, ops)) begin res = n; err = 0; end
    end else begin
      for (int n = seed - 1; err == 1 && n >= 2; n--)
        if (is_prime_cnt(n, ops)) begin res = n; err = 0; end
    end
    if (ops > 65535) ops = 65535;
  endfunction

  // Whenever the block reports idle, its visible state must match the reference.
  always @(negedge clk) begin
    if (!rst && o_ready === 1'b1) begin
      chk("model_res", o_res, exp_res);
      chk("model_err", o_error, exp_err);
      chk("model_ops", o_ops, exp_ops);
    end
  end

  task automatic wait_ready(input string name);
    int k = 0;
    while (o_ready !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk(name, o_ready, 1);
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    i_load = 1'b1;
    i_from = 16'(v);
    @(posedge clk);
    #1;
    i_load  = 1'b0;
    exp_res = v;
    exp_err = 0;
    chk("load_ready", o_ready, 1);
    chk("load_res", o_res, v);
  endtask

  task automatic issue_go(input bit d);
    int r, e, o;
    @(negedge clk);
    i_go  = 1'b1;
    i_dir = d;
    @(posedge clk);
    #1;
    i_go = 1'b0;
    model_search(exp_res, d, r, e, o);
    exp_res = r;
    exp_err = e;
    exp_ops = o;
    chk("go_ready_fall", o_ready, 0);
  endtask

  task automatic do_go(input bit d);
    issue_go(d);
    wait_ready("go_timeout");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_error", o_error, 0);
    chk("rst_res", o_res, 1);
    chk("rst_ops", o_ops, 0);
    rst = 1'b0;

    do_go(1'b0); chk("seq_2", o_res, 2); chk("seq_2_err", o_error, 0);
    do_go(1'b0); chk("seq_3", o_res, 3);
    do_go(1'b0); chk("seq_5", o_res, 5); chk("seq_5_err", o_error, 0);

    do_load(90);
    do_go(1'b0); chk("up90_res", o_res, 97); chk("up90_ops", o_ops, 10);

    do_load(101);
    do_go(1'b1); chk("dn101_res", o_res, 97); chk("dn101_ops", o_ops, 5);
    do_go(1'b1); chk("dn97_res", o_res, 89); chk("dn97_ops", o_ops, 10);

    do_load(65521);
    do_go(1'b0);
    chk("top_err", o_error, 1); chk("top_ready", o_ready, 1); chk("top_res", o_res, 65521);
    do_load(2);
    chk("load_clears_err", o_error, 0);
    do_go(1'b1);
    chk("bot_err", o_error, 1); chk("bot_res", o_res, 2);
    do_load(10);
    do_go(1'b0);
    chk("up10_err", o_error, 0); chk("up10_res", o_res, 11); chk("up10_ops", o_ops, 1);

    // load and go in the same cycle: load wins and no search starts.
    @(negedge clk);
    i_go   = 1'b1;
    i_load = 1'b1;
    i_from = 16'd7;
    @(posedge clk);
    #1;
    i_go    = 1'b0;
    i_load  = 1'b0;
    exp_res = 7;
    exp_err = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("both_ready", o_ready, 1);
      chk("both_res", o_res, 7);
    end

    // Reset while the first divisor test of 1001 is in flight.
    do_load(1000);
    issue_go(1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", o_ready, 0);
    chk("mid_ops", o_ops, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_res = 1;
    exp_err = 0;
    exp_ops = 0;
    chk("abort_ready", o_ready, 1);
    chk("abort_res", o_res, 1);
    chk("abort_ops", o_ops, 0);
    rst = 1'b0;
    do_go(1'b0); chk("after_abort", o_res, 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
